// File: rtl/dmem_mmio.sv
// Data memory with an MMIO window: word RAM with byte-lane stores, a TX byte FIFO,
// a 64-bit cycle counter and a sticky halt flag. Loads are combinational from address.
module dmem_mmio #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic [3:0]  wmask,
    input  logic        wen,
    output logic [31:0] read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt
);
    localparam int         AW       = $clog2(DEPTH);
    localparam int         FW       = $clog2(FIFO_DEPTH);
    localparam logic [3:0] FULL_CNT = 4'(FIFO_DEPTH);

    localparam logic [7:0] OFF_TXDATA = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYC_LO = 8'h08;
    localparam logic [7:0] OFF_CYC_HI = 8'h0C;
    localparam logic [7:0] OFF_HALT   = 8'h10;

    logic [31:0]   r_mem  [DEPTH];
    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [FW-1:0] r_rd_ptr;
    logic [FW-1:0] r_wr_ptr;
    logic [3:0]    r_count;
    logic          r_overflow;
    logic          r_halt;
    logic [63:0]   r_cycle;

    logic          w_sel_ram;
    logic          w_sel_mmio;
    logic [7:0]    w_off;
    logic [AW-1:0] w_ram_idx;
    logic          w_full;
    logic          w_empty;
    logic          w_push_req;
    logic          w_pop;
    logic          w_push;
    logic          w_halt_set;
    logic [31:0]   w_status;
    logic          w_unused_addr;

    assign w_sel_ram     = (address[31:28] == 4'h0);
    assign w_sel_mmio    = (address[31:8] == 24'h100000);
    assign w_off         = address[7:0];
    assign w_ram_idx     = address[AW+1:2];
    assign w_unused_addr = ^{address[27:AW+2], address[1:0]};

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == 4'd0);
    assign w_push_req = wen && wmask[0] && w_sel_mmio && (w_off == OFF_TXDATA);
    assign w_pop      = !w_empty && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push     = !reset && w_push_req && (!w_full || w_pop);
    assign w_halt_set = wen && (wmask != 4'b0000) && w_sel_mmio && (w_off == OFF_HALT);

    assign w_status = {24'h0, r_count, 1'b0, r_overflow, w_empty, w_full};

    assign tx_valid = !w_empty;
    assign tx_data  = w_empty ? 8'h00 : r_fifo[r_rd_ptr];
    assign halt     = r_halt;

    // RAM is never cleared, but a store coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (!reset && wen && w_sel_ram) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) r_mem[w_ram_idx][8*i +: 8] <= write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= 4'd0;
            r_overflow <= 1'b0;
            r_halt     <= 1'b0;
            r_cycle    <= 64'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FW'(1);
            if (w_push && !w_pop)      r_count <= r_count + 4'd1;
            else if (!w_push && w_pop) r_count <= r_count - 4'd1;
            if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
            if (w_halt_set) r_halt <= 1'b1;
            if (!r_halt) r_cycle <= r_cycle + 64'd1;
        end
    end

    always_comb begin
        read_data = 32'h0;
        if (w_sel_ram) begin
            read_data = r_mem[w_ram_idx];
        end else if (w_sel_mmio) begin
            case (w_off)
                OFF_STATUS: read_data = w_status;
                OFF_CYC_LO: read_data = r_cycle[31:0];
                OFF_CYC_HI: read_data = r_cycle[63:32];
                OFF_HALT:   read_data = {31'h0, r_halt};
                default:    read_data = 32'h0;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized bench for dmem_mmio: a queue/array model predicts every output each cycle,
// with directed scenarios whose results are pinned to hand-computed constants.
module tb_dmem_mmio;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int FD    = 8;

    logic        clk;
    logic        reset;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [3:0]  wmask;
    logic        wen;
    logic [31:0] read_data;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;

    dmem_mmio #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .reset(reset), .address(address), .write_data(write_data),
        .wmask(wmask), .wen(wen), .read_data(read_data), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .halt(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] m_mem   [DEPTH];
    bit          m_known [DEPTH];
    logic [7:0]  q[$];
    logic        m_ovf;
    logic        m_halt;
    logic [63:0] m_cyc;
    bit          mvalid;

    int n_cmp;
    int n_fail;

    logic [31:0] s_rd;
    logic        s_txv;
    logic [7:0]  s_txd;
    logic        s_halt;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[31:28] == 4'h0) return m_mem[a[AW+1:2]];
        if (a[31:8] == 24'h100000) begin
            case (a[7:0])
                8'h04: return {24'h0, 4'(q.size()), 1'b0, m_ovf, q.size() == 0, q.size() == FD};
                8'h08: return m_cyc[31:0];
                8'h0C: return m_cyc[63:32];
                8'h10: return {31'h0, m_halt};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic model_step(input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] m, input logic w, input logic rdy);
        bit full, pop, mmio, pushreq;
        int idx;
        if (r) begin
            q.delete();
            m_ovf  = 1'b0;
            m_halt = 1'b0;
            m_cyc  = 64'd0;
            return;
        end
        full    = (q.size() == FD);
        pop     = (q.size() != 0) && rdy;
        mmio    = (a[31:8] == 24'h100000);
        pushreq = w && m[0] && mmio && (a[7:0] == 8'h00);
        if (pop) void'(q.pop_front());
        if (pushreq) begin
            if (!full || pop) q.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (!m_halt) m_cyc = m_cyc + 64'd1;
        if (w && (m != 4'b0) && mmio && (a[7:0] == 8'h10)) m_halt = 1'b1;
        if (w && (a[31:28] == 4'h0)) begin
            idx = int'(a[AW+1:2]);
            for (int i = 0; i < 4; i++)
                if (m[i]) m_mem[idx][8*i +: 8] = d[8*i +: 8];
            if (m == 4'hF) m_known[idx] = 1'b1;
        end
    endtask

    // One clock: drive, compare outputs against the model mid-cycle, then advance the model.
    task automatic cycle(input logic r, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] m, input logic w, input logic rdy);
        reset = r; address = a; write_data = d; wmask = m; wen = w; tx_ready = rdy;
        @(negedge clk);
        s_rd = read_data; s_txv = tx_valid; s_txd = tx_data; s_halt = halt;
        if (mvalid) begin
            if (a[31:28] != 4'h0 || m_known[a[AW+1:2]])
                chk("read_data", read_data, exp_rd(a));
            chk("tx_valid", tx_valid, q.size() != 0);
            chk("tx_data", tx_data, (q.size() != 0) ? q[0] : 8'h00);
            chk("halt", halt, m_halt);
        end
        @(posedge clk);
        model_step(r, a, d, m, w, rdy);
        if (r) mvalid = 1'b1;
        #1;
    endtask

    task automatic rst_cycle();
        cycle(1'b1, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic rd(input logic [31:0] a, input logic rdy);
        cycle(1'b0, a, 32'h0, 4'h0, 1'b0, rdy);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        cycle(1'b0, a, d, m, 1'b1, 1'b0);
    endtask

    localparam logic [31:0] TXD  = 32'h1000_0000;
    localparam logic [31:0] STAT = 32'h1000_0004;
    localparam logic [31:0] CLO  = 32'h1000_0008;
    localparam logic [31:0] HLT  = 32'h1000_0010;

    initial begin
        logic [7:0]  offs [9];
        logic [31:0] a, tmp;
        logic        r, w;
        n_cmp = 0; n_fail = 0; mvalid = 1'b0;
        m_ovf = 1'b0; m_halt = 1'b0; m_cyc = 64'd0;
        for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 32'h0; m_known[i] = 1'b0; end
        offs = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h01};

        // Reset state
        rst_cycle();
        rd(STAT, 1'b0);
        chk("reset_status", s_rd, 32'h0000_0002);
        chk("reset_txv", s_txv, 1'b0);
        chk("reset_txd", s_txd, 8'h00);
        chk("reset_halt", s_halt, 1'b0);

        for (int i = 0; i < DEPTH; i++) wr(32'(i) << 2, $urandom, 4'hF);

        // Byte-lane merge
        wr(32'h40, 32'hAABBCCDD, 4'hF);
        wr(32'h40, 32'h11223344, 4'h5);
        rd(32'h40, 1'b0);
        chk("byte_mask", s_rd, 32'hAA22CC44);

        // Read during write returns old data
        wr(32'h80, 32'h0, 4'hF);
        wr(32'h80, 32'h5, 4'hF);
        chk("rdw_old", s_rd, 32'h0);
        rd(32'h80, 1'b0);
        chk("rdw_new", s_rd, 32'h5);

        // Aliasing and unmapped
        wr(32'h1000, 32'hCAFEF00D, 4'hF);
        rd(32'h0, 1'b0);
        chk("alias", s_rd, 32'hCAFEF00D);
        rd(32'h2000_0000, 1'b0);
        chk("unmapped_rd", s_rd, 32'h0);
        wr(32'h2000_0000, 32'h12345678, 4'hF);
        rd(32'h0, 1'b0);
        chk("unmapped_wr", s_rd, 32'hCAFEF00D);

        // FIFO fill with overflow, then drain
        rst_cycle();
        for (int i = 0; i < 9; i++) wr(TXD, 32'h41 + 32'(i), 4'h1);
        rd(STAT, 1'b0);
        chk("fill_status", s_rd, 32'h85);
        for (int i = 0; i < 8; i++) begin
            rd(STAT, 1'b1);
            chk("drain_data", s_txd, 8'h41 + 8'(i));
        end
        rd(STAT, 1'b0);
        chk("drain_status", s_rd, 32'h06);
        chk("drain_txv", s_txv, 1'b0);

        // Full push with simultaneous pop
        rst_cycle();
        for (int i = 0; i < 8; i++) wr(TXD, 32'h30 + 32'(i), 4'h1);
        cycle(1'b0, TXD, 32'h5A, 4'h1, 1'b1, 1'b1);
        chk("fullpp_head", s_txd, 8'h30);
        rd(STAT, 1'b0);
        chk("fullpp_status", s_rd, 32'h81);
        for (int i = 0; i < 8; i++) rd(STAT, 1'b1);
        chk("fullpp_last", s_txd, 8'h5A);

        // Halt freezes the cycle counter; reset clears both
        rst_cycle();
        rd(CLO, 1'b0);
        chk("cyc_after_reset", s_rd, 32'd0);
        wr(HLT, 32'h1, 4'hF);
        rd(CLO, 1'b0);
        chk("halt_set", s_halt, 1'b1);
        chk("cyc_at_halt", s_rd, 32'd2);
        rd(CLO, 1'b0);
        chk("cyc_frozen", s_rd, 32'd2);
        rst_cycle();
        rd(CLO, 1'b0);
        chk("halt_cleared", s_halt, 1'b0);
        chk("cyc_cleared", s_rd, 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            tmp = $urandom;
            r = ($urandom_range(0, 199) == 0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = {4'h0, tmp[27:12], 6'b0, 4'($urandom_range(0, 15)), tmp[1:0]};
                5, 6, 7, 8:    a = {24'h100000, offs[$urandom_range(0, 8)]};
                default:       a = {4'($urandom_range(2, 15)), tmp[27:0]};
            endcase
            w = 1'($urandom_range(0, 1));
            if (a == HLT && $urandom_range(0, 9) != 0) w = 1'b0;
            cycle(r, a, $urandom, 4'($urandom), w, $urandom_range(0, 2) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_mmio.md
DMEM_MMIO -- requirements
Module: dmem_mmio

Interface
REQ-001 Parameter DEPTH, default 1024, RAM size in 32-bit words; power of two.
REQ-002 Parameter FIFO_DEPTH, default 8, TX FIFO entries; power of two, at most 15.
REQ-003 The block SHALL have one clock and one synchronous, active-high reset; ports as follows.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 address  input  32  byte address from the processor data port.
REQ-007 write_data  input  32  store data, byte lanes aligned to address[1:0]=0.
REQ-008 wmask  input  4  byte-lane write enables; bit i covers write_data[8i+7:8i].
REQ-009 wen  input  1  store strobe, qualified by wmask.
REQ-010 read_data  output  32  load data for the current address.
REQ-011 tx_valid  output  1  TX FIFO head valid.
REQ-012 tx_data  output  8  TX FIFO head byte.
REQ-013 tx_ready  input  1  consumer accepts head this cycle.
REQ-014 halt  output  1  sticky program-halt flag.

Function
REQ-015 Decode: address[31:28]=0x0 selects RAM; address[31:8]=0x100000 selects MMIO; everything else is unmapped.
REQ-016 RAM word index SHALL be address[log2(DEPTH)+1:2]; higher address bits within the RAM region alias (wrap).
REQ-017 read_data SHALL be combinational from address with no read latency: RAM word, MMIO register, or 0 if unmapped.
REQ-018 RAM writes SHALL occur at the rising edge when wen=1; only lanes with wmask[i]=1 change.
REQ-019 A load from the address stored in the same cycle SHALL return the old contents; the new data is visible from the next cycle.
REQ-020 MMIO 0x00 TXDATA: a write with wen=1 and wmask[0]=1 pushes write_data[7:0]; reads return 0.
REQ-021 MMIO 0x04 STATUS (read-only): bit0 full, bit1 empty, bit2 overflow (sticky), bits[7:4] count, all other bits 0.
REQ-022 MMIO 0x08 CYCLE_LO and 0x0C CYCLE_HI SHALL return the live low and high words of a 64-bit cycle counter; writes are ignored.
REQ-023 MMIO 0x10 HALT: any write with wen=1 and wmask!=0 sets halt; reads return {31'b0,halt}.
REQ-024 Other MMIO offsets and unmapped addresses SHALL read 0 and ignore writes.
REQ-025 FIFO pop SHALL occur when tx_valid=1 and tx_ready=1; tx_valid=(count!=0); tx_data=head entry.
REQ-026 Push when full without a simultaneous pop: the byte is dropped, overflow is set, and count is unchanged.
REQ-027 Push when full with a simultaneous pop: both happen, the byte is accepted, and count is unchanged.
REQ-028 Push when empty: count becomes 1 next cycle; tx_valid is low in the push cycle, so there is no same-cycle bypass.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
REQ-030 The cycle counter SHALL increment by 1 each cycle while halt=0, wrap from 2^64-1 to 0, and freeze while halt=1.
REQ-031 While halt=1: RAM writes, FIFO push and FIFO pop SHALL remain functional.

Reset
REQ-032 On reset: FIFO pointers and count 0, overflow 0, halt 0, cycle counter 0, tx_valid 0.
REQ-033 On reset: tx_data SHALL be 0 while the FIFO is empty.
REQ-034 RAM contents SHALL NOT be cleared by reset.
REQ-035 Reset SHALL take priority over any simultaneous push, pop, write or halt set.
REQ-036 Reset asserted mid-operation SHALL discard queued FIFO bytes.

Verification
REQ-037 Byte mask: store 0xAABBCCDD to 0x40 with wmask=1111, then 0x11223344 with wmask=0101 -> load 0x40 = 0xAA22CC44.
REQ-038 Read-during-write: in the cycle storing 0x5 to 0x80, which held 0x0 -> read_data=0x0 that cycle and 0x5 the next.
REQ-039 FIFO fill: 9 pushes of 0x41..0x49 with tx_ready=0 -> STATUS=0x85, 0x49 dropped; then tx_ready=1 drains 0x41..0x48 in order, one per cycle, and STATUS ends 0x06.
REQ-040 Full push+pop: FIFO full with tx_ready=1 and a push of 0x5A -> count stays 8, overflow unchanged, 0x5A is the last byte out.
REQ-041 Halt: write 1 to 0x10000010 at cycle N -> halt=1 next cycle; CYCLE_LO frozen from then on; reset returns halt=0 and CYCLE_LO=0.
REQ-042 Aliasing/unmapped: with DEPTH=1024, store to 0x1000 and load 0x0 -> same word; load 0x20000000 -> 0; store there leaves all RAM unchanged.
